// File: rtl/alu_share_arb.sv
// rtl/alu_share_arb.sv - round-robin arbiter sharing one combinational ALU among NUM_REQ requesters
// Optional per-requester stall counters are built when ALU_SHARE_ARB_STATS_EN is defined.
module alu_share_arb #(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [NUM_REQ-1:0]      i_req_valid,
  output logic [NUM_REQ-1:0]      o_req_ready,
  input  logic [NUM_REQ*XLEN-1:0] i_req_op_a,
  input  logic [NUM_REQ*XLEN-1:0] i_req_op_b,
  input  logic [NUM_REQ*4-1:0]    i_req_alu_op,
  output logic [XLEN-1:0]         o_alu_op_a,
  output logic [XLEN-1:0]         o_alu_op_b,
  output logic [3:0]              o_alu_op,
  input  logic [XLEN-1:0]         i_alu_data,
  output logic [NUM_REQ-1:0]      o_rsp_valid,
  input  logic [NUM_REQ-1:0]      i_rsp_ready,
  output logic [NUM_REQ*XLEN-1:0] o_rsp_data
`ifdef ALU_SHARE_ARB_STATS_EN
  ,
  input  logic                    i_stat_clr,
  output logic [NUM_REQ*16-1:0]   o_stall_cnt
`endif
);

  localparam int PW = (NUM_REQ > 2) ? 2 : 1;

  logic [PW-1:0]      ptr_q;
  logic [PW-1:0]      ptr_d;
  logic [PW-1:0]      grant_idx;
  logic               grant_any;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic [XLEN-1:0]    rsp_data_q [NUM_REQ];
  int                 cand;

  // A slot that is draining this cycle may be refilled in the same cycle.
  assign eligible = i_req_valid & (~o_rsp_valid | i_rsp_ready);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (int'(ptr_q) + i) % NUM_REQ;
      if (!grant_any && eligible[cand]) begin
        grant_any   = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = PW'(cand);
      end
    end
    if (i_rst) begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
    end
  end

  assign o_req_ready = grant;

  always_comb begin
    ptr_d = ptr_q;
    if (grant_any) begin
      ptr_d = PW'((int'(grant_idx) + 1) % NUM_REQ);
    end
  end

  // Idle ALU inputs are parked at zero so the shared datapath does not toggle.
  always_comb begin
    o_alu_op_a = '0;
    o_alu_op_b = '0;
    o_alu_op   = '0;
    if (grant_any) begin
      o_alu_op_a = i_req_op_a[int'(grant_idx)*XLEN +: XLEN];
      o_alu_op_b = i_req_op_b[int'(grant_idx)*XLEN +: XLEN];
      o_alu_op   = i_req_alu_op[int'(grant_idx)*4 +: 4];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr_q       <= '0;
      o_rsp_valid <= '0;
      for (int k = 0; k < NUM_REQ; k++) begin
        rsp_data_q[k] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (grant[k]) begin
          o_rsp_valid[k] <= 1'b1;
          rsp_data_q[k]  <= i_alu_data;
        end else if (i_rsp_ready[k]) begin
          o_rsp_valid[k] <= 1'b0;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_rsp
    assign o_rsp_data[g*XLEN +: XLEN] = rsp_data_q[g];
  end

`ifdef ALU_SHARE_ARB_STATS_EN
  logic [15:0] stall_q [NUM_REQ];

  // Clear wins over increment; counters stick at all-ones.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        stall_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (i_stat_clr) begin
          stall_q[k] <= '0;
        end else if (i_req_valid[k] && !grant[k] && (stall_q[k] != 16'hFFFF)) begin
          stall_q[k] <= stall_q[k] + 16'd1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    assign o_stall_cnt[g*16 +: 16] = stall_q[g];
  end
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// tb/tb_alu_share_arb.sv - scoreboard bench for alu_share_arb with directed and random traffic
// Stats checks are compiled when ALU_SHARE_ARB_STATS_EN is defined.
module tb_alu_share_arb;
  localparam int NR = 2;
  localparam int XL = 32;

  logic              clk = 1'b0;
  logic              i_rst;
  logic [NR-1:0]     i_req_valid;
  logic [NR-1:0]     o_req_ready;
  logic [NR*XL-1:0]  i_req_op_a;
  logic [NR*XL-1:0]  i_req_op_b;
  logic [NR*4-1:0]   i_req_alu_op;
  logic [XL-1:0]     o_alu_op_a;
  logic [XL-1:0]     o_alu_op_b;
  logic [3:0]        o_alu_op;
  logic [XL-1:0]     i_alu_data;
  logic [NR-1:0]     o_rsp_valid;
  logic [NR-1:0]     i_rsp_ready;
  logic [NR*XL-1:0]  o_rsp_data;
`ifdef ALU_SHARE_ARB_STATS_EN
  logic              i_stat_clr;
  logic [NR*16-1:0]  o_stall_cnt;
`endif

  logic [XL-1:0] req_a [NR];
  logic [XL-1:0] req_b [NR];
  logic [3:0]    req_op [NR];
  logic [XL-1:0] nx_a [NR];
  logic [XL-1:0] nx_b [NR];
  logic [3:0]    nx_op [NR];
  logic          nx_clr;

  logic [NR-1:0] m_valid;
  int            m_ptr;
  logic [XL-1:0] exp_q [NR][$];
  logic [NR-1:0] prev_v;
  int            prev_g;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_share_arb #(.NUM_REQ(NR), .XLEN(XL)) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_op_a   (i_req_op_a),
    .i_req_op_b   (i_req_op_b),
    .i_req_alu_op (i_req_alu_op),
    .o_alu_op_a   (o_alu_op_a),
    .o_alu_op_b   (o_alu_op_b),
    .o_alu_op     (o_alu_op),
    .i_alu_data   (i_alu_data),
    .o_rsp_valid  (o_rsp_valid),
    .i_rsp_ready  (i_rsp_ready),
    .o_rsp_data   (o_rsp_data)
`ifdef ALU_SHARE_ARB_STATS_EN
    ,
    .i_stat_clr   (i_stat_clr),
    .o_stall_cnt  (o_stall_cnt)
`endif
  );

  function automatic logic [XL-1:0] alu_ref(input logic [3:0] op, input logic [XL-1:0] a, input logic [XL-1:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd3: return (a < b) ? 32'd1 : 32'd0;
      4'd4: return a ^ b;
      4'd5: return a | b;
      4'd6: return a & b;
      4'd7: return a << b[4:0];
      4'd8: return a >> b[4:0];
      4'd9: return $unsigned($signed(a) >>> b[4:0]);
      default: return '0;
    endcase
  endfunction

  always_comb i_alu_data = alu_ref(o_alu_op, o_alu_op_a, o_alu_op_b);

  always_comb begin
    i_req_op_a   = '0;
    i_req_op_b   = '0;
    i_req_alu_op = '0;
    for (int k = 0; k < NR; k++) begin
      i_req_op_a[k*XL +: XL] = req_a[k];
      i_req_op_b[k*XL +: XL] = req_b[k];
      i_req_alu_op[k*4 +: 4] = req_op[k];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One arbitration cycle: apply inputs at the falling edge, predict the grant from the round-robin rule.
  task automatic step(input logic [NR-1:0] v, input logic [NR-1:0] rr, output int g);
    logic [NR-1:0] exp_rdy;
    @(negedge clk);
    for (int k = 0; k < NR; k++) begin
      req_a[k]  = nx_a[k];
      req_b[k]  = nx_b[k];
      req_op[k] = nx_op[k];
    end
`ifdef ALU_SHARE_ARB_STATS_EN
    i_stat_clr = nx_clr;
`endif
    i_req_valid = v;
    i_rsp_ready = rr;
    #1;
    g = -1;
    for (int i = 0; i < NR; i++) begin
      int k;
      k = (m_ptr + i) % NR;
      if (g < 0 && v[k] && (!m_valid[k] || rr[k])) g = k;
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", 64'(o_req_ready), 64'(exp_rdy));
    chk("rsp_valid", 64'(o_rsp_valid), 64'(m_valid));
    if (g >= 0) begin
      chk("alu_drive", {o_alu_op, o_alu_op_a, o_alu_op_b}, {nx_op[g], nx_a[g], nx_b[g]});
      exp_q[g].push_back(alu_ref(nx_op[g], nx_a[g], nx_b[g]));
    end else begin
      chk("alu_idle", {o_alu_op, o_alu_op_a, o_alu_op_b}, 64'd0);
    end
    for (int k = 0; k < NR; k++) begin
      if (k == g) m_valid[k] = 1'b1;
      else if (rr[k]) m_valid[k] = 1'b0;
    end
    if (g >= 0) m_ptr = (g + 1) % NR;
    prev_v = v;
    prev_g = g;
  endtask

  task automatic set_req(input int k, input logic [3:0] op, input logic [XL-1:0] a, input logic [XL-1:0] b);
    nx_op[k] = op;
    nx_a[k]  = a;
    nx_b[k]  = b;
  endtask

  // Response monitor: a held response must always equal the oldest expected result for that slot.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!i_rst) begin
        for (int k = 0; k < NR; k++) begin
          if (o_rsp_valid[k]) begin
            if (exp_q[k].size() == 0) begin
              chk("rsp_spurious", 64'(o_rsp_valid[k]), 64'd0);
            end else begin
              chk("rsp_data", 64'(o_rsp_data[k*XL +: XL]), 64'(exp_q[k][0]));
              if (i_rsp_ready[k]) void'(exp_q[k].pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    logic [NR-1:0] v;
    logic [NR-1:0] rr;
    i_rst       = 1'b1;
    i_req_valid = '1;
    i_rsp_ready = '0;
    nx_clr      = 1'b0;
`ifdef ALU_SHARE_ARB_STATS_EN
    i_stat_clr  = 1'b0;
`endif
    for (int k = 0; k < NR; k++) begin
      req_a[k] = 32'h1234 + k; req_b[k] = 32'h55; req_op[k] = 4'd4;
      set_req(k, 4'd0, 32'd0, 32'd0);
    end
    m_valid = '0;
    m_ptr   = 0;
    prev_v  = '0;
    prev_g  = -1;

    #2;
    chk("reset_req_ready", 64'(o_req_ready), 64'd0);
    chk("reset_rsp_valid", 64'(o_rsp_valid), 64'd0);
    chk("reset_rsp_data", 64'(o_rsp_data), 64'd0);
    chk("reset_alu_drive", {o_alu_op, o_alu_op_a, o_alu_op_b}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    i_req_valid = '0;
    i_rst = 1'b0;

    // Contention: alternate 0,1,0,1 from a reset pointer.
    set_req(0, 4'd1, 32'd10, 32'd3);
    set_req(1, 4'd2, 32'hFFFF_FFFF, 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(2'b11, 2'b11, g);
      chk("contention_grant", 64'(g), 64'(i % 2));
      if (i == 1) chk("contention_sub", 64'(o_rsp_data[31:0]), 64'd7);
      if (i == 2) chk("contention_slt", 64'(o_rsp_data[63:32]), 64'd1);
    end
    step(2'b00, 2'b11, g);

    // Single request with one-cycle latency.
    set_req(0, 4'd0, 32'd5, 32'd7);
    step(2'b01, 2'b11, g);
    chk("single_grant", 64'(g), 64'd0);
    step(2'b00, 2'b11, g);
    chk("single_valid", 64'(o_rsp_valid[0]), 64'd1);
    chk("single_data", 64'(o_rsp_data[31:0]), 64'd12);

    // Backpressure on requester 0 while requester 1 keeps flowing.
    set_req(0, 4'd7, 32'd1, 32'd4);
    set_req(1, 4'd4, 32'hF0, 32'h0F);
    step(2'b01, 2'b00, g);
    chk("bp_first_grant", 64'(g), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step(2'b11, 2'b10, g);
      chk("bp_other_grant", 64'(g), 64'd1);
      chk("bp_held_data", 64'(o_rsp_data[31:0]), 64'd16);
    end
    step(2'b11, 2'b11, g);
    chk("bp_release_grant", 64'(g), 64'd0);
    step(2'b00, 2'b11, g);
    chk("bp_new_data", 64'(o_rsp_data[31:0]), 64'd16);

    // Drain and refill the same slot in one cycle.
    set_req(1, 4'd0, 32'd3, 32'd4);
    step(2'b10, 2'b00, g);
    chk("dr_fill_grant", 64'(g), 64'd1);
    set_req(1, 4'd9, 32'h8000_0000, 32'd4);
    step(2'b10, 2'b10, g);
    chk("dr_refill_grant", 64'(g), 64'd1);
    step(2'b00, 2'b00, g);
    chk("dr_valid", 64'(o_rsp_valid[1]), 64'd1);
    chk("dr_data", 64'(o_rsp_data[63:32]), 64'hF800_0000);
    step(2'b00, 2'b11, g);

    // Asynchronous reset with both responses pending.
    step(2'b11, 2'b00, g);
    step(2'b11, 2'b00, g);
    @(negedge clk);
    #3;
    i_rst = 1'b1;
    #1;
    chk("async_rst_rsp_valid", 64'(o_rsp_valid), 64'd0);
    chk("async_rst_req_ready", 64'(o_req_ready), 64'd0);
    chk("async_rst_rsp_data", 64'(o_rsp_data), 64'd0);
    i_req_valid = '0;
    m_valid = '0;
    m_ptr   = 0;
    prev_v  = '0;
    for (int k = 0; k < NR; k++) exp_q[k].delete();
    @(posedge clk);
    @(negedge clk);
    i_rst = 1'b0;
    set_req(0, 4'd5, 32'hA0, 32'h0A);
    set_req(1, 4'd6, 32'hFF, 32'h3C);
    step(2'b11, 2'b11, g);
    chk("post_rst_grant", 64'(g), 64'd0);

    // Random traffic honouring the hold-while-waiting rule.
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < NR; k++) begin
        if (prev_v[k] && prev_g != k) begin
          v[k] = 1'b1;
        end else begin
          v[k] = ($urandom_range(0, 3) != 0);
          set_req(k, 4'($urandom_range(0, 11)), $urandom, ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) : $urandom);
        end
      end
      rr = NR'($urandom);
      step(v, rr, g);
    end
    step(2'b00, 2'b11, g);
    step(2'b00, 2'b11, g);

`ifdef ALU_SHARE_ARB_STATS_EN
    step(2'b10, 2'b00, g);
    nx_clr = 1'b1;
    step(2'b00, 2'b00, g);
    nx_clr = 1'b0;
    for (int i = 0; i < 5; i++) step(2'b10, 2'b00, g);
    step(2'b00, 2'b00, g);
    chk("stall_cnt1_five", 64'(o_stall_cnt[31:16]), 64'd5);
    chk("stall_cnt0_zero", 64'(o_stall_cnt[15:0]), 64'd0);
    nx_clr = 1'b1;
    step(2'b10, 2'b00, g);
    nx_clr = 1'b0;
    step(2'b00, 2'b00, g);
    chk("stall_clr_priority", 64'(o_stall_cnt[31:16]), 64'd0);
    step(2'b10, 2'b00, g);
    repeat (70000) @(posedge clk);
    step(2'b00, 2'b00, g);
    chk("stall_saturate", 64'(o_stall_cnt[31:16]), 64'hFFFF);
`endif

    step(2'b00, 2'b11, g);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Round-robin arbiter that shares one combinational ALU instance between NUM_REQ requesters, e.g. the main execute path, the branch-compare unit and the address-generation unit of a multi-cycle variant of the core.
- Each requester presents an ALU request (operands plus 4-bit op code) with a valid/ready handshake.
- The arbiter grants at most one request per cycle and drives the shared ALU ports.
- It captures the ALU result into a per-requester response register, held with its own valid/ready handshake until accepted.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..4.
- XLEN, 32, operand/result width; must match the ALU.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_req_valid  input  NUM_REQ  per-requester request valid.
- o_req_ready  output  NUM_REQ  per-requester grant (request accepted this cycle).
- i_req_op_a  input  NUM_REQ*XLEN  flattened operand A; requester k uses bits [k*XLEN +: XLEN].
- i_req_op_b  input  NUM_REQ*XLEN  flattened operand B.
- i_req_alu_op  input  NUM_REQ*4  flattened ALU op code. ADD=0, SUB=1, SLT=2, SLTU=3, XOR=4, OR=5, AND=6, SLL=7, SRL=8, SRA=9.
- o_alu_op_a  output  XLEN  operand A to shared ALU.
- o_alu_op_b  output  XLEN  operand B to shared ALU.
- o_alu_op  output  4  op code to shared ALU.
- i_alu_data  input  XLEN  combinational ALU result.
- o_rsp_valid  output  NUM_REQ  per-requester response valid.
- i_rsp_ready  input  NUM_REQ  per-requester response accept.
- o_rsp_data  output  NUM_REQ*XLEN  flattened response data.

Behaviour:
- Reset, asynchronous active-high:
  - o_rsp_valid=0, o_rsp_data=0, round-robin pointer=0, o_req_ready=0.
  - ALU drive outputs are 0.
  - Reset mid-operation discards all pending responses; no response survives reset.
- Eligibility: requester k is eligible when i_req_valid[k]=1 and its response slot is free. Free means o_rsp_valid[k]=0, or o_rsp_valid[k]=1 && i_rsp_ready[k]=1 in the same cycle (slot drains and refills in one cycle).
- Arbitration is combinational within the cycle:
  - Search starts at pointer p and proceeds p, p+1, ..., wrapping modulo NUM_REQ.
  - The first eligible requester wins.
  - o_req_ready is one-hot or zero; never more than one bit set.
- ALU drive:
  - When a grant to k exists, o_alu_op_a/b/op = requester k's fields, combinationally.
  - With no grant, all ALU drive outputs are 0 (ADD of zeros, no toggling).
- Capture: on the clock edge with grant to k, o_rsp_data[k] <= i_alu_data and o_rsp_valid[k] <= 1.
  - Latency: request accepted in cycle N gives response visible in cycle N+1.
  - Throughput: 1 op/cycle total.
- Pointer update: after a grant to k, p <= (k+1) mod NUM_REQ. With no grant, p holds.
- Response handshake:
  - o_rsp_valid[k] clears on i_rsp_ready[k]=1 unless a new grant to k occurs in the same cycle; in that case valid stays 1 with the new data.
  - o_rsp_data[k] is stable while valid && !ready.
- Requester rules: while i_req_valid[k]=1 and o_req_ready[k]=0, the requester holds its fields stable. Arbitration does not depend on i_rsp_ready of other requesters.
- Op codes outside 0..9 are passed through unchanged; the ALU returns 0 and the arbiter captures it.
- Starvation bound: a continuously valid requester with a free slot is granted within NUM_REQ cycles.

Optional Feature:
- Macro ALU_SHARE_ARB_STATS_EN.
- When defined, the block adds:
  - Input i_stat_clr (1).
  - Output o_stall_cnt (NUM_REQ*16): per-requester 16-bit counter, incremented each cycle i_req_valid[k]=1 && o_req_ready[k]=0, saturating at 0xFFFF.
  - The counters reset to 0 on i_rst and clear to 0 on i_stat_clr. Clear has priority over increment.
- When not defined: the ports are absent and there is no counter logic; all other behaviour is identical.

Test Plan:
- Single request: req0 ADD a=5 b=7 -> o_req_ready[0]=1 same cycle; next cycle o_rsp_valid[0]=1, o_rsp_data[0]=12.
- Contention, NUM_REQ=2, both valid every cycle, responses always accepted, req0 SUB 10-3 and req1 SLT -1<1 -> grants alternate 0,1,0,1. Responses 7 and 1 respectively.
- Backpressure: req0 response held with i_rsp_ready[0]=0 for 3 cycles while req0 stays valid (SLL 1<<4) -> req0 not granted. The held response is unchanged, and req1 is still granted. After ready rises, grant to req0 in the same cycle, new data 16 the next cycle.
- Drain-and-refill: o_rsp_valid[1]=1, i_rsp_ready[1]=1 and req1 valid (SRA 0x80000000>>4) -> grant same cycle; o_rsp_valid[1] stays 1 with data 0xF8000000.
- Reset mid-operation: assert i_rst asynchronously between edges with responses pending -> o_rsp_valid=0 immediately, pointer=0. After release, the first contended grant goes to req0.
- Stats (macro defined): req1 blocked 5 cycles -> o_stall_cnt[1]=5; i_stat_clr pulse -> 0. Force 70000 stall cycles -> saturates at 0xFFFF.
